// File: rtl/hazard3_pwrup_arbiter.sv
// Shares one upstream 4-phase power-up handshake between N_REQ requesters.
// Ports: clk/rst, req_i/ack_o per requester, force_on, up_req/up_ack upstream, up_active.
module hazard3_pwrup_arbiter #(
  parameter int N_REQ   = 2,
  parameter int HOLDOFF = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_REQ-1:0] req_i,
  output logic [N_REQ-1:0] ack_o,
  input  logic             force_on,
  output logic             up_req,
  input  logic             up_ack,
  output logic             up_active
);

  localparam int CW = $clog2(HOLDOFF + 1);

  typedef enum logic [2:0] {
    S_UP         = 3'd0,
    S_HOLD       = 3'd1,
    S_GOING_DOWN = 3'd2,
    S_DOWN       = 3'd3,
    S_GOING_UP   = 3'd4
  } state_t;

  state_t        state;
  state_t        state_n;
  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_n;
  logic          up_req_n;
  logic          up_ok;
  logic          demand;
  logic          idle;

  // Power is good now, or becomes good on this very edge.
  assign up_ok = (state == S_UP) || (state == S_HOLD) ||
                 ((state == S_GOING_UP) && up_ack);
  assign demand = (|req_i) || force_on;
  assign idle   = !demand && !(|ack_o);

  always_comb begin
    state_n  = state;
    cnt_n    = cnt;
    up_req_n = up_req;
    case (state)
      S_UP: begin
        if (idle) begin
          state_n = S_HOLD;
          cnt_n   = CW'(HOLDOFF);
        end
      end
      S_HOLD: begin
        if (demand) begin
          state_n = S_UP;
        end else if (cnt == CW'(1)) begin
          state_n  = S_GOING_DOWN;
          up_req_n = 1'b0;
        end else begin
          cnt_n = cnt - CW'(1);
        end
      end
      S_GOING_DOWN: begin
        // The upstream handshake must finish before we may re-request.
        if (!up_ack) begin
          if (demand) begin
            state_n  = S_GOING_UP;
            up_req_n = 1'b1;
          end else begin
            state_n = S_DOWN;
          end
        end
      end
      S_DOWN: begin
        if (demand) begin
          state_n  = S_GOING_UP;
          up_req_n = 1'b1;
        end
      end
      S_GOING_UP: begin
        if (up_ack) begin
          state_n = S_UP;
        end
      end
      default: begin
        state_n  = S_UP;
        up_req_n = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_UP;
      cnt       <= '0;
      up_req    <= 1'b1;
      ack_o     <= '1;
      up_active <= 1'b1;
    end else begin
      state     <= state_n;
      cnt       <= cnt_n;
      up_req    <= up_req_n;
      ack_o     <= req_i & (ack_o | {N_REQ{up_ok}});
      up_active <= (state_n == S_UP) || (state_n == S_HOLD);
    end
  end

endmodule

// File: tb/tb_hazard3_pwrup_arbiter.sv
// Directed bench for hazard3_pwrup_arbiter (N_REQ=2, HOLDOFF=4).
// Table-driven cycle vectors plus force_on and reset corner sequences.
module tb_hazard3_pwrup_arbiter;

  localparam int HO = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] req_i;
  logic [1:0] ack_o;
  logic       force_on;
  logic       up_req;
  logic       up_ack;
  logic       up_active;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  hazard3_pwrup_arbiter #(.N_REQ(2), .HOLDOFF(HO)) dut (
    .clk      (clk),
    .rst      (rst),
    .req_i    (req_i),
    .ack_o    (ack_o),
    .force_on (force_on),
    .up_req   (up_req),
    .up_ack   (up_ack),
    .up_active(up_active)
  );

  typedef struct {
    logic [1:0] req;
    logic       frc;
    logic       uack;
    logic [1:0] ack;
    logic       ureq;
    logic       act;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic [1:0] rq, input logic f,
                     input logic ua, input logic [1:0] ak,
                     input logic ur, input logic ac);
    vec_t v;
    v.req = rq; v.frc = f; v.uack = ua;
    v.ack = ak; v.ureq = ur; v.act = ac;
    vecs.push_back(v);
  endtask

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  initial begin
    int n;
    // req, force, up_ack -> ack, up_req, up_active
    add(2'b11, 0, 1, 2'b11, 1, 1);
    add(2'b00, 0, 1, 2'b00, 1, 1);
    add(2'b00, 0, 1, 2'b00, 1, 1);
    add(2'b00, 0, 1, 2'b00, 1, 1);
    add(2'b00, 0, 1, 2'b00, 1, 1);
    add(2'b00, 0, 1, 2'b00, 1, 1);
    add(2'b00, 0, 1, 2'b00, 0, 0);
    add(2'b00, 0, 1, 2'b00, 0, 0);
    add(2'b00, 0, 1, 2'b00, 0, 0);
    add(2'b00, 0, 0, 2'b00, 0, 0);
    add(2'b10, 0, 0, 2'b00, 1, 0);
    for (int i = 0; i < 5; i++) add(2'b10, 0, 0, 2'b00, 1, 0);
    add(2'b10, 0, 1, 2'b10, 1, 1);
    add(2'b10, 0, 1, 2'b10, 1, 1);
    add(2'b01, 0, 1, 2'b01, 1, 1);
    add(2'b00, 0, 1, 2'b00, 1, 1);
    add(2'b00, 0, 1, 2'b00, 1, 1);
    add(2'b00, 0, 1, 2'b00, 1, 1);
    add(2'b00, 0, 1, 2'b00, 1, 1);
    add(2'b00, 0, 1, 2'b00, 1, 1);
    add(2'b00, 0, 1, 2'b00, 0, 0);
    add(2'b01, 0, 1, 2'b00, 0, 0);
    add(2'b01, 0, 1, 2'b00, 0, 0);
    add(2'b01, 0, 0, 2'b00, 1, 0);
    add(2'b01, 0, 0, 2'b00, 1, 0);
    add(2'b01, 0, 1, 2'b01, 1, 1);
    add(2'b00, 0, 1, 2'b00, 1, 1);
    add(2'b00, 0, 1, 2'b00, 1, 1);
    add(2'b00, 0, 1, 2'b00, 1, 1);
    add(2'b00, 0, 1, 2'b00, 1, 1);
    add(2'b00, 0, 1, 2'b00, 1, 1);
    add(2'b01, 0, 1, 2'b01, 1, 1);
    add(2'b00, 0, 1, 2'b00, 1, 1);
    add(2'b00, 0, 1, 2'b00, 1, 1);

    rst = 1'b1; req_i = 2'b11; force_on = 1'b0; up_ack = 1'b1;
    step();
    step();
    chk("rst_ack", 32'(ack_o), 32'h3);
    chk("rst_up_req", 32'(up_req), 32'h1);
    chk("rst_active", 32'(up_active), 32'h1);
    rst = 1'b0;

    foreach (vecs[i]) begin
      req_i = vecs[i].req;
      force_on = vecs[i].frc;
      up_ack = vecs[i].uack;
      step();
      chk($sformatf("v%0d_ack", i), 32'(ack_o), 32'(vecs[i].ack));
      chk($sformatf("v%0d_up_req", i), 32'(up_req), 32'(vecs[i].ureq));
      chk($sformatf("v%0d_active", i), 32'(up_active), 32'(vecs[i].act));
    end

    // force_on keeps power alive without any acknowledge
    req_i = 2'b00; up_ack = 1'b1; force_on = 1'b1;
    for (int i = 0; i < 100; i++) begin
      step();
      if (i % 10 == 9) begin
        chk($sformatf("frc%0d_up_req", i), 32'(up_req), 32'h1);
        chk($sformatf("frc%0d_ack", i), 32'(ack_o), 32'h0);
      end
    end
    force_on = 1'b0;
    n = 0;
    for (int i = 0; i < 20; i++) begin
      step();
      n++;
      if (!up_req) break;
    end
    chk("frc_off_edges", 32'(n), 32'(HO + 1));

    // reset while upstream is going down
    rst = 1'b1; req_i = 2'b11;
    step();
    chk("mid_rst_up_req", 32'(up_req), 32'h1);
    chk("mid_rst_ack", 32'(ack_o), 32'h3);
    chk("mid_rst_active", 32'(up_active), 32'h1);
    rst = 1'b0;
    step();
    chk("post_rst_ack", 32'(ack_o), 32'h3);
    chk("post_rst_up_req", 32'(up_req), 32'h1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/hazard3_pwrup_arbiter.md
# hazard3_pwrup_arbiter

Shares one upstream 4-phase power-up handshake (bus fabric / SRAM power domain) between `N_REQ` downstream requesters, typically the `pwrup_req`/`pwrup_ack` pairs of several Hazard3 harts plus a debug force-on.
- Keeps the upstream domain powered while any requester holds its request.
- Waits a programmable hold-off before dropping upstream power, to avoid thrashing on short sleeps.
- Grants each downstream acknowledge only once upstream power is confirmed.
- Sits in the always-on clock domain, next to the per-hart power controllers.

## Interface
Parameters:
- `N_REQ`, default 2: number of downstream requesters, 1..16.
- `HOLDOFF`, default 4: idle cycles before upstream power-down, 1..255.

Ports:
- `clk`  input  1: always-on clock.
- `rst`  input  1: reset. One clock; reset is synchronous and active-high.
- `req_i`  input  N_REQ: per-requester power-up request, 4-phase.
- `ack_o`  output  N_REQ: per-requester power-up acknowledge.
- `force_on`  input  1: level, debug keep-alive. Treated as an extra requester that needs no acknowledge.
- `up_req`  output  1: upstream power-up request.
- `up_ack`  input  1: upstream power-up acknowledge.
- `up_active`  output  1: high when upstream power is confirmed, i.e. state is S_UP or S_HOLD.

## Operation
- State register (3 bits): S_UP, S_HOLD, S_GOING_DOWN, S_DOWN, S_GOING_UP.
- `up_ok` = (state is S_UP or S_HOLD) or (state is S_GOING_UP and `up_ack`).
- Per-bit acknowledge update each cycle: `ack_o[i] <= req_i[i] & (ack_o[i] | up_ok)`.
  - Release (req low) always drops the ack next cycle, in any state.
  - Rise waits for `up_ok`.
  - A requester that abandons its request before the ack rises never sees an ack.
- `demand` = any `req_i` bit or `force_on`.
- `idle` = no `demand` and all `ack_o` bits low.
- Transitions:
  - S_UP: `idle` -> S_HOLD, load counter with `HOLDOFF`.
  - S_HOLD: `demand` -> S_UP. Otherwise, if counter == 1 -> S_GOING_DOWN and `up_req`<=0; else decrement the counter.
  - S_GOING_DOWN: while `up_ack` is high, stay, whatever the `demand`; the upstream handshake must complete. When `up_ack` is low: with `demand` -> S_GOING_UP and `up_req`<=1; without `demand` -> S_DOWN.
  - S_DOWN: `demand` -> S_GOING_UP and `up_req`<=1.
  - S_GOING_UP: `up_ack` -> S_UP. Pending acks rise on this same edge, via `up_ok`.
  - Unused encodings -> S_UP with `up_req`<=1.
- The counter is `$clog2(HOLDOFF+1)` bits wide. It is reloaded only on the S_UP->S_HOLD transition.

## Timing
- Reset (synchronous, sampled on `clk`):
  - state=S_UP, `up_req`=1, `ack_o`=all ones, counter=0, `up_active`=1.
  - This mirrors the harts, which hold `pwrup_req` high in reset.
- Upstream reset requirements:
  - `rst` is asserted together with the upstream controller's reset.
  - `up_ack` is high on the first cycle after `rst` deasserts.
  - Reset mid-handshake forces `up_req`=1 immediately.
- Acknowledge latency:
  - Request while S_UP/S_HOLD: `ack_o[i]` rises 1 cycle after `req_i[i]` is sampled high.
  - Request from S_DOWN: `up_req` rises 1 cycle after `req_i` is sampled; `ack_o` rises on the edge that samples `up_ack` high.
- Release latency: `ack_o[i]` falls 1 cycle after `req_i[i]` is sampled low.
- Power-down latency: `up_req` falls `HOLDOFF`+1 edges after the edge on which the last `ack_o` fell, provided no `demand` arrives.
- Boundary conditions:
  - `demand` on the counter==1 cycle of S_HOLD: `demand` wins, `up_req` stays high.
  - Simultaneous rise on one requester and release on another: handled per bit, independently.
  - `force_on` high blocks power-down but never drives any `ack_o`.
  - `up_active` is registered and changes on the same edge as the state.

## Test plan
- Reset release with `req_i`=2'b11 and `up_ack`=1 -> `ack_o`=2'b11 and `up_req`=1 held; no state change.
- Both requests drop at edge 0, `HOLDOFF`=4:
  - `ack_o`=0 after edge 0, S_HOLD after edge 1, `up_req`=0 after edge 5.
  - `up_ack` dropped 3 cycles later -> S_DOWN.
- From S_DOWN, `req_i[1]` rises:
  - `up_req`=1 next edge.
  - `up_ack` raised 6 cycles later -> `ack_o[1]` rises on that sampling edge and `ack_o[0]` stays 0.
- `req_i[0]` rises during S_GOING_DOWN while `up_ack` is still high:
  - `up_req` stays 0 until `up_ack` falls, then goes 1 on the next edge.
  - `ack_o[0]` rises only after `up_ack` returns high.
- In S_HOLD with counter==1, `req_i[0]` pulses high -> S_UP, `up_req` never drops, `ack_o[0]` rises 1 cycle later.
- `force_on`=1 with all requests low for 100 cycles -> `up_req` stays 1 and `ack_o`=0. Deassert `force_on` -> `up_req` falls `HOLDOFF`+1 edges later.
